// File: rtl/text_pkg.sv
// Shared constants, FSM state type and character sanitising for the text scroller.
// Imported by the interface, the prescaler and the scroller top.
package text_pkg;

    localparam int CHAR_W     = 7;
    localparam int NUM_DIGITS = 6;

    localparam logic [CHAR_W-1:0] ASCII_SPACE = 7'h20;
    localparam logic [CHAR_W-1:0] ASCII_DEL   = 7'h7F;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_STATIC,
        ST_SCROLL
    } state_t;

    // Control codes and DEL have no glyph on the 7-seg converter.
    function automatic logic [CHAR_W-1:0] sanitize(input logic [CHAR_W-1:0] c);
        return ((c < ASCII_SPACE) || (c == ASCII_DEL)) ? ASCII_SPACE : c;
    endfunction

endpackage

// File: rtl/text_scroller_if.sv
// Character append / display bus between a text source and the scroller.
// master = text source and display consumer, slave = text_scroller.
interface text_scroller_if #(
    parameter int DEPTH = 32
);
    import text_pkg::*;

    logic [CHAR_W-1:0]            char_in;
    logic                         char_valid;
    logic                         char_ready;
    logic                         msg_clear;
    logic                         scroll_en;
    logic [NUM_DIGITS*CHAR_W-1:0] digits;
    logic [$clog2(DEPTH):0]       msg_len;

    modport master (
        output char_in, char_valid, msg_clear, scroll_en,
        input  char_ready, digits, msg_len
    );

    modport slave (
        input  char_in, char_valid, msg_clear, scroll_en,
        output char_ready, digits, msg_len
    );

endinterface

// File: rtl/scroll_tick_gen.sv
// Scroll prescaler: counts 0..TICK_DIV-1 while enabled, holds while disabled, zeroes on clear.
// Latency: tick is combinational, high during the cycle the count sits at terminal value.
// Backpressure: none; enable low simply freezes the count.
module scroll_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/text_scroller.sv
// Six-digit ASCII text scroller: appends chars to a buffer, shows it static (<6) or rotating (>=6).
// Latency: digits registered, one cycle after buffer/length/start change. Optional: TEXT_SCROLLER_WRAP_PULSE_EN.
// Backpressure: char_ready low when buffer full, during msg_clear and during reset.
module text_scroller
    import text_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 12500000
) (
    input logic            clk,
    input logic            reset,
    text_scroller_if.slave bus
`ifdef TEXT_SCROLLER_WRAP_PULSE_EN
    ,
    output logic           wrap_pulse
`endif
);

    localparam int                DW       = NUM_DIGITS * CHAR_W;
    localparam int                AW       = $clog2(DEPTH);
    localparam logic [AW:0]       LEN_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]       LEN_LAST_STATIC = (AW+1)'(NUM_DIGITS - 1);
    localparam logic [DW-1:0]     ALL_SPACE = {NUM_DIGITS{ASCII_SPACE}};

    state_t              state_q, state_d;
    logic [AW:0]         len_q, len_d;
    logic [AW-1:0]       start_q, start_d;
    logic [DW-1:0]       digits_q, digits_d;
    logic [CHAR_W-1:0]   buffer [DEPTH];

    logic                accept;
    logic                step;
    logic                start_wraps;
    logic [AW:0]         idx;

    assign bus.char_ready = !reset && (len_q != LEN_FULL) && !bus.msg_clear;
    assign accept         = bus.char_valid && bus.char_ready;
    // Wrap is judged against the length before any same-cycle append.
    assign start_wraps    = (({1'b0, start_q} + (AW+1)'(1)) == len_q);

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable ((state_q == ST_SCROLL) && bus.scroll_en),
        .clear  (bus.msg_clear || (state_q != ST_SCROLL)),
        .tick   (step)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        start_d = start_q;
        if (bus.msg_clear) begin
            state_d = ST_EMPTY;
            len_d   = '0;
            start_d = '0;
        end else begin
            if (accept) begin
                len_d = len_q + (AW+1)'(1);
            end
            if (step) begin
                start_d = start_wraps ? '0 : start_q + AW'(1);
            end
            case (state_q)
                ST_EMPTY:  if (accept) state_d = ST_STATIC;
                ST_STATIC: if (accept && (len_q == LEN_LAST_STATIC)) state_d = ST_SCROLL;
                ST_SCROLL: state_d = ST_SCROLL;
                default:   state_d = ST_EMPTY;
            endcase
        end
    end

    // Six parallel buffer reads; display 5 is the leftmost character.
    always_comb begin
        digits_d = ALL_SPACE;
        idx      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            case (state_q)
                ST_STATIC: begin
                    if ((AW+1)'(k) < len_q) begin
                        digits_d[(NUM_DIGITS-1-k)*CHAR_W +: CHAR_W] = buffer[AW'(k)];
                    end
                end
                ST_SCROLL: begin
                    idx = {1'b0, start_q} + (AW+1)'(k);
                    if (idx >= len_q) begin
                        idx = idx - len_q;
                    end
                    digits_d[(NUM_DIGITS-1-k)*CHAR_W +: CHAR_W] = buffer[idx[AW-1:0]];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            len_q    <= '0;
            start_q  <= '0;
            digits_q <= ALL_SPACE;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            start_q  <= start_d;
            digits_q <= digits_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[len_q[AW-1:0]] <= sanitize(bus.char_in);
        end
    end

    assign bus.digits  = digits_q;
    assign bus.msg_len = len_q;

`ifdef TEXT_SCROLLER_WRAP_PULSE_EN
    // Delayed one extra cycle so the pulse lines up with the registered digits.
    logic wrap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q     <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_q     <= step && !bus.msg_clear && start_wraps;
            wrap_pulse <= wrap_q;
        end
    end
`endif

endmodule

// File: doc/text_scroller.md
TEXT_SCROLLER -- requirements
Module: text_scroller

Interface
REQ-001 SHALL have parameter DEPTH, default 32: message buffer capacity in characters, power of two, minimum 8.
REQ-002 SHALL have parameter TICK_DIV, default 12500000: clk cycles per scroll step, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port char_in, input, 7 bits: ASCII character offered for append.
REQ-006 SHALL have port char_valid, input, 1 bit: char_in is offered this cycle.
REQ-007 SHALL have port char_ready, output, 1 bit: an append is accepted this cycle.
REQ-008 SHALL have port msg_clear, input, 1 bit: empty the message.
REQ-009 SHALL have port scroll_en, input, 1 bit: allow scroll stepping.
REQ-010 SHALL have port digits, output, 42 bits: six 7-bit ASCII codes; digits[7i+6:7i] is display i, and display 5 is leftmost.
REQ-011 SHALL have port msg_len, output, clog2(DEPTH)+1 bits: number of stored characters.

Function
REQ-012 SHALL accept a character when char_valid and char_ready are both high; char_ready = (msg_len < DEPTH) and not msg_clear, with no dependency on char_valid.
REQ-013 SHALL store an accepted character at buffer[msg_len] and increment msg_len in the same edge.
REQ-014 SHALL store 0x20 (space) in place of any accepted char_in below 0x20 or equal to 0x7F, so the downstream ASCII-to-7-seg converter always receives 0x20..0x7E.
REQ-015 SHALL run a three-state FSM: EMPTY (msg_len=0), STATIC (1..5), SCROLL (>=6).
REQ-016 SHALL make state transitions follow msg_len after each append or clear; a clear from any state goes to EMPTY.
REQ-017 SHALL keep window start pointer start=0 in EMPTY and STATIC.
REQ-018 SHALL, in EMPTY, drive all six digits to 0x20.
REQ-019 SHALL, in STATIC, drive display (5-k) with buffer[k] for k<msg_len and 0x20 otherwise, so the text is left-justified.
REQ-020 SHALL, in SCROLL, drive display (5-k) with buffer[(start+k) mod msg_len] for k=0..5, computed as start+k minus msg_len when start+k >= msg_len.
REQ-021 SHALL count the prescaler 0..TICK_DIV-1 only while in SCROLL with scroll_en high; it holds its value when scroll_en is low and resets to 0 on leaving SCROLL.
REQ-022 SHALL issue one step at prescaler terminal count: start becomes start+1, wrapping to 0 when start+1 equals the current msg_len.
REQ-023 SHALL let an append and a step in the same cycle both take effect, with the step wrap using the pre-append msg_len.
REQ-024 SHALL give priority to msg_clear over a simultaneous char_valid or step: msg_len, start and prescaler all become 0 and the offered character is dropped.
REQ-025 SHALL register digits, updating them exactly one cycle after any change to buffer, msg_len or start.

Reset
REQ-026 SHALL, while reset is asserted, force msg_len=0, start=0, prescaler=0, state EMPTY, digits all 0x20, and char_ready low.
REQ-027 SHALL leave buffer contents uninitialised by reset; they are unobservable because msg_len=0.
REQ-028 SHALL, when reset is asserted mid-scroll, abandon the message, and SHALL assert char_ready in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, when macro TEXT_SCROLLER_WRAP_PULSE_EN is defined, add output wrap_pulse (1 bit), high for exactly one cycle, coincident with digits showing start=0 after a step that wrapped start to 0; its reset value is 0.
REQ-030 SHALL, without TEXT_SCROLLER_WRAP_PULSE_EN, have no wrap_pulse port and no related logic.

Structure
REQ-031 SHALL take ASCII_SPACE (0x20), ASCII_DEL (0x7F), NUM_DIGITS (6), CHAR_W (7) and the FSM state typedef from shared package text_pkg.
REQ-032 SHALL implement the prescaler as sub-module scroll_tick_gen (inputs clk, reset, enable, clear; 1-cycle tick output).
REQ-033 SHALL implement the buffer as a DEPTH x 7 register array with six parallel combinational reads.

Verification (DEPTH=32, TICK_DIV=4)
REQ-034 SHALL cover: reset released -> digits=six 0x20, msg_len=0, char_ready=1 the next cycle.
REQ-035 SHALL cover: append "HI" -> display5=0x48, display4=0x49, displays 3..0=0x20; no change after 20 cycles with scroll_en=1.
REQ-036 SHALL cover: append "ABCDEFG", scroll_en=1 -> window "BCDEFG" 4 cycles after entering SCROLL, "GABCDE" after 24, and "ABCDEF" after 28 with wrap_pulse high for 1 cycle if enabled.
REQ-037 SHALL cover: 33 back-to-back valid chars -> char_ready=0 after the 32nd is accepted, msg_len=32, and the 33rd is not stored.
REQ-038 SHALL cover: append 0x0A, then 0x7F -> both stored and displayed as 0x20.
REQ-039 SHALL cover: msg_clear together with char_valid mid-scroll -> msg_len=0, digits all 0x20 the following cycle, and the character is not stored.
